// File: rtl/led_fade_pwm_if.sv
// led_fade_pwm_if: LED PIO target bits in, PWM drive and busy flag out
interface led_fade_pwm_if #(
    parameter int NUM_LEDS = 8
);
    logic [NUM_LEDS-1:0] leds_in;
    logic [NUM_LEDS-1:0] leds_out;
    logic                busy;
    modport master (output leds_in, input leds_out, input busy);
    modport slave  (input leds_in, output leds_out, output busy);
endinterface

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: fades LED PIO on/off bits into brightness ramps driving 8-bit PWM; define LED_FADE_GAMMA_EN for a squared duty curve
module led_fade_pwm #(
    parameter int NUM_LEDS = 8,
    parameter int FADE_DIV = 7812
) (
    input logic           clk_clk,
    input logic           reset_reset,
    led_fade_pwm_if.slave bus
);
    logic [NUM_LEDS-1:0] r_leds_q, r_leds_out, w_diff, w_pwm;
    logic [7:0]          r_bright [NUM_LEDS];
    logic [7:0]          w_level  [NUM_LEDS];
    logic [19:0]         r_fade_cnt;
    logic [7:0]          r_pwm_cnt;
    logic                r_busy, w_fade_tick;
    assign w_fade_tick = r_fade_cnt == 20'(FADE_DIV - 1);
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
`ifdef LED_FADE_GAMMA_EN
        assign w_level[i] = 8'((16'(r_bright[i]) * 16'(r_bright[i])) >> 8);
`else
        assign w_level[i] = r_bright[i];
`endif
        // target is all-ones or all-zeros, so the replicated bit is the target byte
        assign w_diff[i] = r_bright[i] != {8{r_leds_q[i]}};
        assign w_pwm[i]  = (r_bright[i] == 8'hFF) | (w_level[i] > r_pwm_cnt);
    end
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_leds_q   <= '0;
            r_fade_cnt <= '0;
            r_pwm_cnt  <= '0;
            r_leds_out <= '0;
            r_busy     <= 1'b0;
            for (int c = 0; c < NUM_LEDS; c++) r_bright[c] <= '0;
        end else begin
            r_leds_q   <= bus.leds_in;
            r_fade_cnt <= w_fade_tick ? '0 : r_fade_cnt + 20'd1;
            r_pwm_cnt  <= r_pwm_cnt + 8'd1;
            r_leds_out <= w_pwm;
            r_busy     <= |w_diff;
            // stepping only while bright differs from target saturates at 0 and 255
            for (int c = 0; c < NUM_LEDS; c++)
                if (w_fade_tick && w_diff[c])
                    r_bright[c] <= r_leds_q[c] ? r_bright[c] + 8'd1 : r_bright[c] - 8'd1;
        end
    end
    assign bus.leds_out = r_leds_out;
    assign bus.busy     = r_busy;
endmodule
